hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage MIPS core (IF/ID/EX/MEM/WB).
- Sits beside the MCU decoder and consumes its per-instruction ID-stage control fields.
- Tracks in-flight destination registers, generates PC/IF-ID enables, ID/EX bubbles, branch flushes, EX-operand forward selects and mult/div busy stalls.
- Keeps a saturating stall-cycle counter for bring-up.

---
 rtl/mips_pipe_pkg.sv | 44 ++++
 rtl/md_busy_timer.sv | 32 +++
 rtl/hazard_ctrl.sv | 107 ++++++++++
 tb/tb_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core.
// Holds the forward-select encoding, register index width and the
// per-stage tracking record used by the hazard controller and by the
// datapath forward muxes.
package mips_pipe_pkg;

   localparam int REG_W = 5;

   // EX operand source selects
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;

   // Tracking record for an in-flight instruction
   typedef struct packed {
      logic             valid;
      logic             wreg;
      logic [REG_W-1:0] wdst;
      logic             load;
   } stage_t;

   localparam stage_t STAGE_EMPTY = '0;

   // True when the stage will write register r; $0 never counts.
   function automatic logic stage_writes(input stage_t s, input logic [REG_W-1:0] r);
      return s.valid && s.wreg && (s.wdst == r) && (r != '0);
   endfunction

   // Forward select for one EX operand. MEM wins over WB; a load in MEM
   // is never forwarded because its data is not available yet.
   function automatic logic [1:0] fwd_sel(input stage_t mem, input stage_t wb,
                                          input logic ex_valid, input logic [REG_W-1:0] r);
      logic [1:0] sel;
      sel = FWD_RF;
      if (ex_valid) begin
         if (stage_writes(mem, r) && !mem.load)
            sel = FWD_MEM;
         else if (stage_writes(wb, r))
            sel = FWD_WB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer.
// Loads MD_CYCLES when a mult/div enters EX, then counts down to zero.
// Ports:
//   clk   pipeline clock
//   rst_n asynchronous active-low reset
//   load  a mult/div instruction advances into EX this cycle
//   busy  counter is nonzero
module md_busy_timer #(
   parameter int MD_CYCLES = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic busy
);

   localparam logic [7:0] MD_LOAD = 8'(MD_CYCLES);

   logic [7:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (load)
         count <= MD_LOAD;
      else if (count != '0)
         count <= count - 8'd1;
   end

   assign busy = (count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage MIPS core.
// Tracks destination registers of instructions in EX/MEM/WB and derives
// stall, flush and forward controls plus the mult/div busy interlock.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   id_*                 ID-stage control fields from the decoder
//   ex_br_taken          branch/jump resolved taken in EX
//   pc_en, ifid_en       front-end enables (low while stalling)
//   ifid_flush           IF/ID loads NOP (taken branch)
//   idex_bubble          ID/EX loads NOP (stall or flush)
//   fwd_a, fwd_b         EX operand source selects for rs / rt
//   md_busy              mult/div unit busy
//   stall_cycles         saturating count of stalled cycles
module hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MD_CYCLES = 32,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_use_rs,
   input  logic             id_use_rt,
   input  logic             id_wreg,
   input  logic [4:0]       id_wdst,
   input  logic             id_is_load,
   input  logic             id_is_md,
   input  logic             id_is_mfhilo,
   input  logic             ex_br_taken,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             md_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + CNT_W'(1);
   endfunction

   stage_t     ex_st, mem_st, wb_st;
   logic [4:0] ex_rs, ex_rt;

   logic load_use, md_stall, stall, flush, md_load;

   // ---- ID stage: hazard detection against EX ----
   assign load_use = ex_st.load && id_valid &&
                     ((id_use_rs && stage_writes(ex_st, id_rs)) ||
                      (id_use_rt && stage_writes(ex_st, id_rt)));
   assign md_stall = md_busy && id_valid && (id_is_md || id_is_mfhilo);

   // A taken branch squashes the ID instruction, so it cannot stall.
   assign flush = ex_br_taken;
   assign stall = (load_use || md_stall) && !flush;

   assign pc_en       = !stall;
   assign ifid_en     = !stall;
   assign ifid_flush  = flush;
   assign idex_bubble = stall || flush;

   assign md_load = id_valid && id_is_md && !stall && !flush;

   md_busy_timer #(.MD_CYCLES(MD_CYCLES)) u_md_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (md_load),
      .busy  (md_busy)
   );

   // ---- ID -> EX -> MEM -> WB tracking ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_st  <= STAGE_EMPTY;
         mem_st <= STAGE_EMPTY;
         wb_st  <= STAGE_EMPTY;
         ex_rs  <= '0;
         ex_rt  <= '0;
      end else begin
         if (stall || flush)
            ex_st <= STAGE_EMPTY;
         else
            ex_st <= '{valid: id_valid, wreg: id_wreg, wdst: id_wdst, load: id_is_load};
         ex_rs  <= id_rs;
         ex_rt  <= id_rt;
         mem_st <= ex_st;
         wb_st  <= mem_st;
      end
   end

   // ---- EX stage: operand forwarding ----
   assign fwd_a = fwd_sel(mem_st, wb_st, ex_st.valid, ex_rs);
   assign fwd_b = fwd_sel(mem_st, wb_st, ex_st.valid, ex_rt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cycles <= '0;
      else if (stall)
         stall_cycles <= sat_inc(stall_cycles);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

   localparam int CNT_W = 5;   // small so the mult/div stall run reaches saturation

   logic       clk = 1'b0;
   logic       rst_n;
   logic       id_valid, id_use_rs, id_use_rt, id_wreg, id_is_load, id_is_md, id_is_mfhilo;
   logic [4:0] id_rs, id_rt, id_wdst;
   logic       ex_br_taken;
   logic       pc_en, ifid_en, ifid_flush, idex_bubble, md_busy;
   logic [1:0] fwd_a, fwd_b;
   logic [CNT_W-1:0] stall_cycles;

   int checks = 0;
   int errors = 0;
   int n;

   hazard_ctrl #(.MD_CYCLES(32), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_wreg      (id_wreg),
      .id_wdst      (id_wdst),
      .id_is_load   (id_is_load),
      .id_is_md     (id_is_md),
      .id_is_mfhilo (id_is_mfhilo),
      .ex_br_taken  (ex_br_taken),
      .pc_en        (pc_en),
      .ifid_en      (ifid_en),
      .ifid_flush   (ifid_flush),
      .idex_bubble  (idex_bubble),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .md_busy      (md_busy),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic [4:0] wd, input logic ld, input logic md,
                         input logic mf);
      id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
      id_wreg = wr;  id_wdst = wd;  id_is_load = ld;  id_is_md = md;  id_is_mfhilo = mf;
   endtask

   task automatic nop();
      set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // advance one clock; inputs are then changed at posedge+1, checks at posedge+2
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      ex_br_taken = 1'b0;
      nop();
      #12;
      chk("rst_pc_en", pc_en, 1);
      chk("rst_ifid_en", ifid_en, 1);
      chk("rst_ifid_flush", ifid_flush, 0);
      chk("rst_idex_bubble", idex_bubble, 0);
      chk("rst_fwd_a", fwd_a, 0);
      chk("rst_fwd_b", fwd_b, 0);
      chk("rst_md_busy", md_busy, 0);
      chk("rst_stall_cycles", stall_cycles, 0);
      rst_n = 1'b1;
      tick();

      // add $3,$1,$2 then sub $4,$3,$5 back-to-back
      set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0, 0, 0);
      tick();
      set_id(1, 5'd3, 5'd5, 1, 1, 1, 5'd4, 0, 0, 0);
      #1;
      chk("alu_dep_no_stall", pc_en, 1);
      tick();
      nop();
      #1;
      chk("alu_dep_fwd_a_mem", fwd_a, 2'b01);
      chk("alu_dep_fwd_b_rf", fwd_b, 2'b00);

      // add $8 ; nop ; sub $4,$8,$8 -> both operands from WB
      tick();
      set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd8, 0, 0, 0);
      tick();
      nop();
      tick();
      set_id(1, 5'd8, 5'd8, 1, 1, 1, 5'd4, 0, 0, 0);
      tick();
      nop();
      #1;
      chk("nop_gap_fwd_a_wb", fwd_a, 2'b10);
      chk("nop_gap_fwd_b_wb", fwd_b, 2'b10);

      // add $9 ; add $9 ; sub $x,$9 -> MEM beats WB
      tick();
      set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd9, 0, 0, 0);
      tick();
      set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd9, 0, 0, 0);
      tick();
      set_id(1, 5'd9, 5'd9, 1, 1, 1, 5'd4, 0, 0, 0);
      tick();
      nop();
      #1;
      chk("prio_fwd_a_mem", fwd_a, 2'b01);
      chk("prio_fwd_b_mem", fwd_b, 2'b01);

      // lw $2 ; add $6,$2,$7 -> one stall cycle
      tick();
      set_id(1, 5'd29, 5'd0, 1, 0, 1, 5'd2, 1, 0, 0);
      tick();
      set_id(1, 5'd2, 5'd7, 1, 1, 1, 5'd6, 0, 0, 0);
      #1;
      chk("lu_pc_en", pc_en, 0);
      chk("lu_ifid_en", ifid_en, 0);
      chk("lu_idex_bubble", idex_bubble, 1);
      chk("lu_ifid_flush", ifid_flush, 0);
      chk("lu_cnt_before", stall_cycles, 0);
      tick();
      #1;
      chk("lu_release_pc_en", pc_en, 1);
      chk("lu_cnt_after", stall_cycles, 1);
      tick();
      nop();
      #1;
      chk("lu_fwd_a_wb", fwd_a, 2'b10);
      chk("lu_fwd_b_rf", fwd_b, 2'b00);

      // register 0: add $0 ; lw $0 ; add $1,$0,$0
      tick();
      set_id(1, 5'd1, 5'd2, 1, 1, 1, 5'd0, 0, 0, 0);
      tick();
      set_id(1, 5'd29, 5'd0, 1, 0, 1, 5'd0, 1, 0, 0);
      tick();
      set_id(1, 5'd0, 5'd0, 1, 1, 1, 5'd1, 0, 0, 0);
      #1;
      chk("r0_no_stall", pc_en, 1);
      tick();
      nop();
      #1;
      chk("r0_fwd_a", fwd_a, 2'b00);
      chk("r0_fwd_b", fwd_b, 2'b00);

      // taken branch in the same cycle as a load-use match
      tick();
      set_id(1, 5'd29, 5'd0, 1, 0, 1, 5'd2, 1, 0, 0);
      tick();
      set_id(1, 5'd2, 5'd7, 1, 1, 1, 5'd6, 0, 0, 0);
      ex_br_taken = 1'b1;
      #1;
      chk("br_ifid_flush", ifid_flush, 1);
      chk("br_idex_bubble", idex_bubble, 1);
      chk("br_pc_en", pc_en, 1);
      chk("br_ifid_en", ifid_en, 1);
      tick();
      ex_br_taken = 1'b0;
      nop();
      #1;
      chk("br_cnt_unchanged", stall_cycles, 1);
      chk("br_flush_clear", ifid_flush, 0);

      // mult ; mfhi -> stall for 32 cycles
      tick();
      set_id(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, 1, 0);
      #1;
      chk("md_idle_busy", md_busy, 0);
      chk("md_enter_pc_en", pc_en, 1);
      tick();
      set_id(1, 5'd0, 5'd0, 0, 0, 1, 5'd10, 0, 0, 1);
      #1;
      chk("md_busy_set", md_busy, 1);
      chk("md_mfhi_stall", pc_en, 0);
      n = 0;
      while (pc_en === 1'b0 && n < 100) begin
         n++;
         tick();
         #1;
      end
      chk("md_stall_len", n, 32);
      chk("md_busy_fall", md_busy, 0);
      chk("md_cnt_saturated", stall_cycles, 31);
      tick();
      nop();
      #1;
      chk("md_after_mfhi_busy", md_busy, 0);

      // second mult while busy also stalls; then reset mid-busy
      tick();
      set_id(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, 1, 0);
      tick();
      set_id(1, 5'd6, 5'd7, 1, 1, 0, 5'd0, 0, 1, 0);
      #1;
      chk("md2_busy", md_busy, 1);
      chk("md2_stall", pc_en, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_md_busy", md_busy, 0);
      chk("arst_md_pc_en", pc_en, 1);
      chk("arst_md_cnt", stall_cycles, 0);
      nop();
      #2;
      rst_n = 1'b1;

      // reset in the middle of a load-use stall
      tick();
      set_id(1, 5'd29, 5'd0, 1, 0, 1, 5'd2, 1, 0, 0);
      tick();
      set_id(1, 5'd2, 5'd7, 1, 1, 1, 5'd6, 0, 0, 0);
      #1;
      chk("arst_lu_stall", pc_en, 0);
      rst_n = 1'b0;
      #1;
      chk("arst_lu_pc_en", pc_en, 1);
      chk("arst_lu_bubble", idex_bubble, 0);
      chk("arst_lu_cnt", stall_cycles, 0);
      #2;
      rst_n = 1'b1;
      tick();
      #1;
      chk("post_rst_fwd_a", fwd_a, 2'b00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
